// File: rtl/parallel_to_serial_pkg.sv
// Shared types and sizing helpers for parallel_to_serial_ctrl.
// P2S_PARITY_EN adds an even-parity beat after the data bits.
package parallel_to_serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_e;

    function automatic int unsigned cnt_width(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

    function automatic int unsigned beats_per_word(input int unsigned data_w);
`ifdef P2S_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/parallel_to_serial_ctrl.sv
// Parallel-to-serial converter with valid/ready on both sides, LSB- or MSB-first.
// Build option P2S_PARITY_EN appends an even-parity beat to every word.
module parallel_to_serial_ctrl
    import parallel_to_serial_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] parallel_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    output logic              serial_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              empty_o
);

    localparam int unsigned BEATS = beats_per_word(DATA_W);
    localparam int unsigned CNT_W = cnt_width(DATA_W);

    if (DATA_W < 2) begin : g_bad_width
        $error("parallel_to_serial_ctrl: DATA_W must be >= 2");
    end

    p2s_state_e       r_state;
    p2s_state_e       w_state_nxt;
    logic [BEATS-1:0] r_shift;
    logic [BEATS-1:0] w_shift_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_serial;
    logic             w_serial_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_empty;
    logic             w_empty_nxt;

    logic [BEATS-1:0] w_load_vec;
    logic             w_beat;
    logic             w_load_ready;
    logic             w_load;
    logic [CNT_W-1:0] w_cnt_inc;

    // Word as transmitted: data bits in send order, parity always last.
`ifdef P2S_PARITY_EN
    logic w_parity;
    assign w_parity   = ^parallel_i;
    assign w_load_vec = MSB_FIRST ? {parallel_i, w_parity} : {w_parity, parallel_i};
`else
    assign w_load_vec = parallel_i;
`endif

    assign w_beat       = r_valid && ready_i;
    assign w_load_ready = (r_state == IDLE) || (w_beat && r_last);
    assign w_load       = load_valid_i && w_load_ready;
    assign w_cnt_inc    = r_cnt + CNT_W'(1);

    // Next-state and datapath; a load on the last beat restarts the word with no bubble.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_serial_nxt = r_serial;
        w_valid_nxt  = r_valid;
        w_last_nxt   = r_last;
        w_empty_nxt  = r_empty;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt  = SHIFT;
                    w_serial_nxt = MSB_FIRST ? w_load_vec[BEATS-1] : w_load_vec[0];
                    w_shift_nxt  = MSB_FIRST ? (w_load_vec << 1) : (w_load_vec >> 1);
                    w_cnt_nxt    = '0;
                    w_valid_nxt  = 1'b1;
                    w_last_nxt   = 1'b0;
                    w_empty_nxt  = 1'b0;
                end
            end
            SHIFT: begin
                if (w_beat) begin
                    if (r_last) begin
                        if (w_load) begin
                            w_serial_nxt = MSB_FIRST ? w_load_vec[BEATS-1] : w_load_vec[0];
                            w_shift_nxt  = MSB_FIRST ? (w_load_vec << 1) : (w_load_vec >> 1);
                            w_cnt_nxt    = '0;
                            w_last_nxt   = 1'b0;
                        end else begin
                            w_state_nxt = IDLE;
                            w_valid_nxt = 1'b0;
                            w_last_nxt  = 1'b0;
                            w_empty_nxt = 1'b1;
                        end
                    end else begin
                        w_serial_nxt = MSB_FIRST ? r_shift[BEATS-1] : r_shift[0];
                        w_shift_nxt  = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
                        w_cnt_nxt    = w_cnt_inc;
                        w_last_nxt   = (w_cnt_inc == CNT_W'(BEATS - 1));
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_serial <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_cnt    <= w_cnt_nxt;
            r_serial <= w_serial_nxt;
            r_valid  <= w_valid_nxt;
            r_last   <= w_last_nxt;
            r_empty  <= w_empty_nxt;
        end
    end

    assign load_ready_o = w_load_ready;
    assign serial_o     = r_serial;
    assign valid_o      = r_valid;
    assign last_o       = r_last;
    assign empty_o      = r_empty;

endmodule

// File: tb/tb_parallel_to_serial_ctrl.sv
// Bench for parallel_to_serial_ctrl: LSB-first and MSB-first instances driven in lockstep.
// Honours P2S_PARITY_EN when defined for the build.
module tb_parallel_to_serial_ctrl;

    localparam int unsigned DW = 4;
`ifdef P2S_PARITY_EN
    localparam int unsigned BEATS = DW + 1;
`else
    localparam int unsigned BEATS = DW;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] parallel_i;
    logic          load_valid_i;
    logic          ready_i;
    logic          lrdy_l, ser_l, val_l, last_l, emp_l;
    logic          lrdy_m, ser_m, val_m, last_m, emp_m;

    always #5 clk = ~clk;

    parallel_to_serial_ctrl #(.DATA_W(DW), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset_n(reset_n), .parallel_i(parallel_i),
        .load_valid_i(load_valid_i), .load_ready_o(lrdy_l),
        .serial_o(ser_l), .valid_o(val_l), .ready_i(ready_i),
        .last_o(last_l), .empty_o(emp_l)
    );

    parallel_to_serial_ctrl #(.DATA_W(DW), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset_n(reset_n), .parallel_i(parallel_i),
        .load_valid_i(load_valid_i), .load_ready_o(lrdy_m),
        .serial_o(ser_m), .valid_o(val_m), .ready_i(ready_i),
        .last_o(last_m), .empty_o(emp_m)
    );

    typedef struct {
        logic b_l;
        logic b_m;
        logic last;
    } beat_t;

    typedef struct {
        logic          ld;
        logic [DW-1:0] data;
        logic          rdy;
        logic          e_lrdy;
        logic          e_valid;
        logic          e_empty;
    } vec_t;

    beat_t sb[$];
    vec_t  tbl[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected beats of one word, in send order for each instance.
    task automatic push_word(input logic [DW-1:0] d);
        beat_t b;
        for (int i = 0; i < int'(DW); i++) begin
            b.b_l  = d[i];
            b.b_m  = d[int'(DW) - 1 - i];
            b.last = (i == int'(BEATS) - 1);
            sb.push_back(b);
        end
`ifdef P2S_PARITY_EN
        b.b_l  = ^d;
        b.b_m  = ^d;
        b.last = 1'b1;
        sb.push_back(b);
`endif
    endtask

    // Once per cycle: check the presented bit against the scoreboard, record accepted words.
    task automatic monitor();
        chk("valid_lockstep", 32'(val_m), 32'(val_l));
        if (val_l) begin
            if (sb.size() == 0) begin
                chk("unexpected_bit", 32'(1), 32'(0));
            end else begin
                chk("serial_lsb", 32'(ser_l), 32'(sb[0].b_l));
                chk("serial_msb", 32'(ser_m), 32'(sb[0].b_m));
                chk("last_lsb", 32'(last_l), 32'(sb[0].last));
                chk("last_msb", 32'(last_m), 32'(sb[0].last));
                if (ready_i) void'(sb.pop_front());
            end
        end
        if (load_valid_i && lrdy_l) push_word(parallel_i);
    endtask

    task automatic drive(input logic ld, input logic [DW-1:0] d, input logic rdy);
        load_valid_i = ld;
        parallel_i   = d;
        ready_i      = rdy;
        #1;
        monitor();
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic ld, input logic [DW-1:0] d, input logic rdy);
        drive(ld, d, rdy);
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_empty"}, 32'({emp_l, emp_m}), 32'(2'b11));
        chk({tag, "_valid"}, 32'({val_l, val_m}), 32'(2'b00));
        chk({tag, "_last"}, 32'({last_l, last_m}), 32'(2'b00));
        chk({tag, "_serial"}, 32'({ser_l, ser_m}), 32'(2'b00));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        int            sent;
        reset_n      = 1'b0;
        load_valid_i = 1'b0;
        parallel_i   = '0;
        ready_i      = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_load_ready", 32'({lrdy_l, lrdy_m}), 32'(2'b11));
        reset_n = 1'b1;

        // Single words at full rate, then idle.
        foreach (w[i]) w[i] = 1'b0;
        tbl.push_back('{1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b1});
        for (int k = 1; k <= int'(BEATS); k++)
            tbl.push_back('{1'b0, 4'b0000, 1'b1, (k == int'(BEATS)), 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b1});
        for (int k = 1; k <= int'(BEATS); k++)
            tbl.push_back('{1'b0, 4'b0000, 1'b1, (k == int'(BEATS)), 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1});
        foreach (tbl[i]) begin
            load_valid_i = tbl[i].ld;
            parallel_i   = tbl[i].data;
            ready_i      = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_load_ready", i), 32'({lrdy_l, lrdy_m}), 32'({2{tbl[i].e_lrdy}}));
            chk($sformatf("tbl%0d_valid", i), 32'({val_l, val_m}), 32'({2{tbl[i].e_valid}}));
            chk($sformatf("tbl%0d_empty", i), 32'({emp_l, emp_m}), 32'({2{tbl[i].e_empty}}));
            monitor();
            tick();
        end

        // Backpressure after the 2nd bit: bit 3 and its status must hold for 3 cycles.
        step(1'b1, 4'b0110, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'b0000, 1'b0);
            chk("stall_valid", 32'({val_l, val_m}), 32'(2'b11));
            chk("stall_last", 32'({last_l, last_m}), 32'(2'b00));
            chk("stall_depth", 32'(sb.size()), 32'(BEATS - 2));
            tick();
        end
        for (int k = 0; k < int'(BEATS) - 1; k++) step(1'b0, 4'b0000, 1'b1);
        drive(1'b0, 4'b0000, 1'b1);
        chk("bp_done_empty", 32'({emp_l, emp_m}), 32'(2'b11));
        chk("bp_done_sb", 32'(sb.size()), 32'(0));
        tick();

        // Back-to-back: 4'h5 held during 4'hA, accepted on A's last beat, no gap.
        step(1'b1, 4'hA, 1'b1);
        for (int i = 0; i < 2 * int'(BEATS); i++) begin
            drive((i < int'(BEATS)), 4'h5, 1'b1);
            chk($sformatf("b2b%0d_valid", i), 32'({val_l, val_m}), 32'(2'b11));
            chk($sformatf("b2b%0d_empty", i), 32'({emp_l, emp_m}), 32'(2'b00));
            if (i < int'(BEATS))
                chk($sformatf("b2b%0d_load_ready", i), 32'(lrdy_l), 32'(i == int'(BEATS) - 1));
            tick();
        end
        drive(1'b0, 4'h0, 1'b1);
        chk("b2b_end_empty", 32'({emp_l, emp_m}), 32'(2'b11));
        chk("b2b_end_sb", 32'(sb.size()), 32'(0));
        tick();

        // Asynchronous reset mid-word, then a fresh word must start at its first bit.
        step(1'b1, 4'b1011, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        load_valid_i = 1'b0;
        reset_n      = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sb.delete();
        tick();
        reset_n = 1'b1;
        step(1'b1, 4'b1011, 1'b1);
        for (int k = 0; k < int'(BEATS); k++) step(1'b0, 4'b0000, 1'b1);
        drive(1'b0, 4'b0000, 1'b1);
        chk("restart_empty", 32'({emp_l, emp_m}), 32'(2'b11));
        chk("restart_sb", 32'(sb.size()), 32'(0));
        tick();

        // Random words with random backpressure, bounded cycle budget.
        sent = 0;
        w    = DW'($urandom);
        for (int c = 0; c < 400 && (sent < 8 || sb.size() != 0 || val_l); c++) begin
            drive((sent < 8), w, ($urandom_range(0, 3) != 0));
            if (load_valid_i && lrdy_l) begin
                sent++;
                w = DW'($urandom);
            end
            tick();
        end
        chk("rand_words_sent", 32'(sent), 32'(8));
        chk("rand_drained", 32'({sb.size() == 0, val_l}), 32'(2'b10));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/parallel_to_serial_ctrl.md
Name: parallel_to_serial_ctrl

Overview:
Parametrised parallel-to-serial converter with valid/ready handshakes on both sides.
- Accepts a DATA_W-bit word from an upstream producer.
- Shifts the word out one bit per accepted beat, LSB-first or MSB-first.
- Supports downstream backpressure and back-to-back words with no bubble.
- Sits between register-level producers and single-wire serial links in the day-to-day datapath blocks.

Parameters:
- DATA_W, 8: parallel word width; legal range >= 2, enforced by an elaboration-time assertion.
- MSB_FIRST, 0: 0 = bit 0 is sent first; 1 = bit DATA_W-1 is sent first.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- parallel_i  in  DATA_W  parallel word; sampled only on load handshake.
- load_valid_i  in  1  upstream presents a word.
- load_ready_o  out  1  block can accept a word this cycle; combinational.
- serial_o  out  1  current serial bit; registered.
- valid_o  out  1  serial_o is valid; registered.
- ready_i  in  1  downstream consumes serial_o this cycle.
- last_o  out  1  serial_o is the final bit of the current word; registered.
- empty_o  out  1  no word held and no bit pending; registered.

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE, shift register = 0, bit counter = 0, serial_o = 0, valid_o = 0, last_o = 0, empty_o = 1.
- States: IDLE and SHIFT.
- Load accept = load_valid_i && load_ready_o.
- load_ready_o = (state == IDLE) || (valid_o && ready_i && last_o).
- Beat = valid_o && ready_i.
- IDLE, on load accept:
  - Capture parallel_i.
  - Next cycle: valid_o = 1 and serial_o = first bit (bit 0, or bit DATA_W-1 if MSB_FIRST).
  - Bit counter = 0; empty_o = 0; go to SHIFT.
- SHIFT, beat on a non-last bit: present the next bit in the following cycle and increment the counter.
- SHIFT with valid_o high and ready_i low: hold serial_o, valid_o, last_o and the counter unchanged.
- last_o = 1 exactly while the counter equals DATA_W-1 and valid_o = 1.
- Beat on the last bit with a simultaneous load accept: next cycle presents the first bit of the new word. Stay in SHIFT, no idle cycle, empty_o stays 0.
- Beat on the last bit with no load: next cycle valid_o = 0, last_o = 0, empty_o = 1, state = IDLE. serial_o holds its last value (don't-care).
- load_valid_i while SHIFT and not on the last beat: ignored, load_ready_o = 0; upstream must hold the word.
- Latency: load accept to first valid bit = 1 cycle. Word throughput = DATA_W beats when ready_i is held at 1.
- Counter width: $clog2(DATA_W+1). It never exceeds DATA_W-1 (DATA_W with parity).
- Reset asserted mid-word: the word is dropped and all outputs return to reset values immediately.

Optional Feature:
- Macro: P2S_PARITY_EN.
- Defined:
  - One extra beat follows the data bits, carrying even parity (XOR of all DATA_W bits), computed at load.
  - last_o asserts on the parity beat, not on data bit DATA_W-1.
  - Word length = DATA_W+1 beats.
- Undefined: no parity logic is present; word length = DATA_W beats.

Decomposition:
- Package parallel_to_serial_pkg holds:
  - state enum typedef (IDLE, SHIFT);
  - function computing counter width from DATA_W;
  - function returning beats per word (DATA_W or DATA_W+1).
- No sub-module: shift register, counter and FSM live in one module; a separate counter block adds nothing.

Test Plan:
- Reset, then idle: empty_o = 1, valid_o = 0, load_ready_o = 1, serial_o = 0.
- DATA_W = 4, MSB_FIRST = 0, load 4'b1011, ready_i = 1 -> serial_o = 1,1,0,1 on 4 consecutive cycles; last_o on the 4th; then empty_o = 1.
- MSB_FIRST = 1, load 4'b1011 -> serial_o = 1,0,1,1.
- Backpressure: ready_i low for 3 cycles after the 2nd bit -> serial_o, last_o and the counter hold; the stream resumes with the 3rd bit; no bit is lost or repeated.
- Back-to-back: 4'hA loaded, then 4'h5 held valid; accepted on 4'hA's last beat -> 8 contiguous valid bits 0,1,0,1,1,0,1,0; empty_o never asserts.
- Reset mid-word after 2 bits -> outputs at reset values asynchronously; the next load restarts at bit 0. With P2S_PARITY_EN, 4'b1011 -> 5th beat = 1 with last_o asserted.
